usb3_scram_ctrl: RTL and testbench

//   Sequences the 32-bit Gen1 TX scrambler LFSR per USB 3.0 rules.

---
 rtl/usb3_scram_ctrl.sv | 129 ++++++++++++
 tb/tb_usb3_scram_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/usb3_scram_ctrl.sv
`timescale 1ns/1ps
// Purpose: classifies Gen1 TX words, drives scrambler LFSR reset/advance, picks raw vs scrambled bytes, flags partial SKP.
// Latency: LFSR controls are combinational from the current word; out_* are registered (1 cycle).
// Backpressure: none; accepts a word on every tx_valid cycle, idle cycles hold outputs and LFSR.
module usb3_scram_ctrl #(
  parameter logic [7:0]  COM_SYM       = 8'hBC,
  parameter logic [7:0]  SKP_SYM       = 8'h3C,
  parameter int          TS_BODY_WORDS = 3,
  parameter logic [15:0] SCRAM_INIT    = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        tx_valid,
  input  logic [31:0] tx_data,
  input  logic [3:0]  tx_datak,
  input  logic        scram_disable,
  input  logic        err_clr,
  output logic        lfsr_en,
  output logic        lfsr_rst,
  output logic [15:0] lfsr_init,
  output logic [31:0] lfsr_din,
  input  logic [31:0] lfsr_dout,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_datak,
  output logic        scram_active,
  output logic        align_err
);

  localparam int CW = (TS_BODY_WORDS < 1) ? 1 : $clog2(TS_BODY_WORDS + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DISABLED} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_ts_cnt;
  logic [3:0]      w_com_b;
  logic [3:0]      w_skp_b;
  logic            w_comw;
  logic            w_tsw;
  logic            w_skpw;
  logic            w_pskp;
  logic [31:0]     w_sel_data;

  // Per-byte K-symbol detection and whole-word classification.
  always_comb begin
    w_com_b = 4'b0;
    w_skp_b = 4'b0;
    for (int i = 0; i < 4; i++) begin
      w_com_b[i] = tx_datak[i] & (tx_data[8*i +: 8] == COM_SYM);
      w_skp_b[i] = tx_datak[i] & (tx_data[8*i +: 8] == SKP_SYM);
    end
  end

  assign w_comw = |w_com_b;
  assign w_tsw  = &w_com_b;
  assign w_skpw = &w_skp_b;
  assign w_pskp = (|w_skp_b) & ~w_skpw;

  // LFSR stays in lock regardless of state: COM reseeds, SKP and idle hold.
  assign lfsr_rst     = tx_valid & w_comw;
  assign lfsr_en      = tx_valid & ~w_comw & ~w_skpw;
  assign lfsr_init    = SCRAM_INIT;
  assign lfsr_din     = tx_data;
  assign scram_active = (r_state == S_ACTIVE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state: disable overrides everything; resync waits for a COM.
  always_comb begin
    w_state_nxt = r_state;
    if (scram_disable) begin
      w_state_nxt = S_DISABLED;
    end else begin
      case (r_state)
        S_IDLE:     if (tx_valid && w_comw) w_state_nxt = S_ACTIVE;
        S_ACTIVE:   w_state_nxt = S_ACTIVE;
        S_DISABLED: w_state_nxt = S_IDLE;
        default:    w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Count down the unscrambled TS1/TS2 body words that follow a 4xCOM word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ts_cnt <= '0;
    end else if (tx_valid) begin
      if (w_tsw)                              r_ts_cnt <= CW'(TS_BODY_WORDS);
      else if (!w_skpw && (r_ts_cnt != '0))   r_ts_cnt <= r_ts_cnt - CW'(1);
    end
  end

  // Byte select: scramble only D bytes of non-COM words outside a TS body while active.
  always_comb begin
    w_sel_data = tx_data;
    for (int i = 0; i < 4; i++) begin
      if ((r_state == S_ACTIVE) && !tx_datak[i] && !w_comw && (r_ts_cnt == '0))
        w_sel_data[8*i +: 8] = lfsr_dout[8*i +: 8];
    end
  end

  // Output register; data/K hold across idle cycles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= 32'h0;
      out_datak <= 4'h0;
    end else begin
      out_valid <= tx_valid;
      if (tx_valid) begin
        out_data  <= w_sel_data;
        out_datak <= tx_datak;
      end
    end
  end

  // Sticky partial-SKP flag; a new partial SKP beats a same-cycle clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                align_err <= 1'b0;
    else if (tx_valid && w_pskp) align_err <= 1'b1;
    else if (err_clr)            align_err <= 1'b0;
  end

endmodule

// File: tb/tb_usb3_scram_ctrl.sv
`timescale 1ns/1ps
// Purpose: directed scoreboard bench for usb3_scram_ctrl.
// Latency: expects out_* one cycle after each accepted word.
// Backpressure: none; the bench drives words freely.
module tb_usb3_scram_ctrl;

  localparam logic [31:0] KEY = 32'hA5A5_5A5A;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        tx_valid;
  logic [31:0] tx_data;
  logic [3:0]  tx_datak;
  logic        scram_disable;
  logic        err_clr;
  logic        lfsr_en;
  logic        lfsr_rst;
  logic [15:0] lfsr_init;
  logic [31:0] lfsr_din;
  logic [31:0] lfsr_dout;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  out_datak;
  logic        scram_active;
  logic        align_err;

  int n_chk  = 0;
  int n_fail = 0;
  logic [35:0] sb_q[$];

  // Stand-in scrambler: keystream is a fixed XOR of the word being sent.
  assign lfsr_dout = tx_data ^ KEY;

  always #5 clock = ~clock;

  usb3_scram_ctrl dut (
    .clock(clock), .reset_n(reset_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_datak(tx_datak), .scram_disable(scram_disable), .err_clr(err_clr),
    .lfsr_en(lfsr_en), .lfsr_rst(lfsr_rst), .lfsr_init(lfsr_init),
    .lfsr_din(lfsr_din), .lfsr_dout(lfsr_dout), .out_valid(out_valid),
    .out_data(out_data), .out_datak(out_datak), .scram_active(scram_active),
    .align_err(align_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle();
    @(posedge clock);
    #1;
  endtask

  // Drive one word, check the combinational LFSR controls, queue the expected output.
  task automatic send(input string nm, input logic [31:0] d, input logic [3:0] k,
                      input logic [31:0] exp_d, input logic exp_en, input logic exp_rst);
    tx_data  = d;
    tx_datak = k;
    tx_valid = 1'b1;
    #1;
    chk({nm, " lfsr_en"},  {31'b0, lfsr_en},  {31'b0, exp_en});
    chk({nm, " lfsr_rst"}, {31'b0, lfsr_rst}, {31'b0, exp_rst});
    chk({nm, " lfsr_din"}, lfsr_din, d);
    sb_q.push_back({exp_d, k});
    @(posedge clock);
    #1;
    tx_valid = 1'b0;
  endtask

  // Monitor: pop and compare whenever the DUT presents a word.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out: got %h with empty scoreboard", out_data);
      end else begin
        logic [35:0] e;
        e = sb_q.pop_front();
        chk("out_data", out_data, e[35:4]);
        chk("out_datak", {28'b0, out_datak}, {28'b0, e[3:0]});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; tx_valid = 1'b0; tx_data = 32'h0; tx_datak = 4'h0;
    scram_disable = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst out_data", out_data, 32'h0);
    chk("rst out_datak", {28'b0, out_datak}, 32'h0);
    chk("rst align_err", {31'b0, align_err}, 32'h0);
    chk("rst scram_active", {31'b0, scram_active}, 32'h0);
    chk("lfsr_init", {16'b0, lfsr_init}, 32'h0000_FFFF);
    reset_n = 1'b1;
    idle();

    // 1: D word in IDLE passes raw, LFSR advances
    send("t1_d", 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 1'b0);
    chk("t1 scram_active", {31'b0, scram_active}, 32'h0);

    // 2: TSW, 3 raw body words, then scrambled
    send("t2_tsw", 32'hBCBC_BCBC, 4'hF, 32'hBCBC_BCBC, 1'b0, 1'b1);
    chk("t2 scram_active", {31'b0, scram_active}, 32'h1);
    send("t2_b1", 32'h1111_1111, 4'h0, 32'h1111_1111, 1'b1, 1'b0);
    send("t2_b2", 32'h2222_2222, 4'h0, 32'h2222_2222, 1'b1, 1'b0);
    send("t2_b3", 32'h3333_3333, 4'h0, 32'h3333_3333, 1'b1, 1'b0);
    send("t2_d5", 32'h1234_5678, 4'h0, 32'hB791_0C22, 1'b1, 1'b0);

    // 3: SKPW between two D words holds the LFSR; mixed K word
    send("t3_d1", 32'h0000_FFFF, 4'h0, 32'hA5A5_A5A5, 1'b1, 1'b0);
    send("t3_skp", 32'h3C3C_3C3C, 4'hF, 32'h3C3C_3C3C, 1'b0, 1'b0);
    send("t3_d2", 32'h1234_5678, 4'h1, 32'hB791_0C78, 1'b1, 1'b0);
    chk("t3 align_err", {31'b0, align_err}, 32'h0);

    // 4: partial SKP sets align_err; clear; set wins over same-cycle clear
    send("t4_pskp", 32'h3C3C_0000, 4'hC, 32'h3C3C_5A5A, 1'b1, 1'b0);
    chk("t4 align_err set", {31'b0, align_err}, 32'h1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;
    chk("t4 align_err clr", {31'b0, align_err}, 32'h0);
    err_clr = 1'b1;
    send("t4_pskp1", 32'h0000_003C, 4'h1, 32'hA5A5_5A3C, 1'b1, 1'b0);
    err_clr = 1'b0;
    chk("t4 set beats clr", {31'b0, align_err}, 32'h1);
    err_clr = 1'b1;
    idle();
    err_clr = 1'b0;

    // 5: disable -> raw with controls still toggling, release -> IDLE, COM resyncs
    scram_disable = 1'b1;
    idle();
    chk("t5 scram_active dis", {31'b0, scram_active}, 32'h0);
    send("t5_dis1", 32'h1234_5678, 4'h0, 32'h1234_5678, 1'b1, 1'b0);
    send("t5_discom", 32'h0000_00BC, 4'h1, 32'h0000_00BC, 1'b0, 1'b1);
    scram_disable = 1'b0;
    send("t5_rel", 32'h1234_5678, 4'h0, 32'h1234_5678, 1'b1, 1'b0);
    send("t5_idle", 32'h1234_5678, 4'h0, 32'h1234_5678, 1'b1, 1'b0);
    chk("t5 scram_active idle", {31'b0, scram_active}, 32'h0);
    send("t5_com", 32'hBC00_0000, 4'h8, 32'hBC00_0000, 1'b0, 1'b1);
    send("t5_d", 32'h1234_5678, 4'h0, 32'hB791_0C22, 1'b1, 1'b0);
    chk("t5 scram_active", {31'b0, scram_active}, 32'h1);

    // 6: reset mid TS body (ts_cnt=2) clears everything immediately
    send("t6_tsw", 32'hBCBC_BCBC, 4'hF, 32'hBCBC_BCBC, 1'b0, 1'b1);
    send("t6_b1", 32'h1111_1111, 4'h0, 32'h1111_1111, 1'b1, 1'b0);
    idle();
    reset_n = 1'b0;
    tx_valid = 1'b1; tx_data = 32'h5555_5555; tx_datak = 4'h0;
    #1;
    chk("t6 out_valid", {31'b0, out_valid}, 32'h0);
    chk("t6 out_data", out_data, 32'h0);
    chk("t6 scram_active", {31'b0, scram_active}, 32'h0);
    idle();
    tx_valid = 1'b0;
    reset_n = 1'b1;
    idle();
    send("t6_com", 32'h0000_00BC, 4'h1, 32'h0000_00BC, 1'b0, 1'b1);
    send("t6_d", 32'h1234_5678, 4'h0, 32'hB791_0C22, 1'b1, 1'b0);

    repeat (3) idle();
    chk("sb_empty", sb_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
